// File: rtl/burst_ram_arbiter_if.sv
// Requester-side BurstRAM port bundle: one instance per cache port.
// master = the requester (cache), slave = the arbiter port it plugs into.
interface burst_ram_arbiter_if #(
    parameter int DEPTH_BITWIDTH = 4
) ();
    logic                      cmd;
    logic                      cmd_en;
    logic [DEPTH_BITWIDTH-1:0] addr;
    logic [63:0]               wr_data;
    logic [7:0]                data_mask;
    logic [63:0]               rd_data;
    logic                      rd_data_ready;
    logic                      busy;
    logic                      cmd_ack;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_ready, busy, cmd_ack
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_ready, busy, cmd_ack
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-port arbiter in front of a single BurstRAM. Port a (instruction cache)
// and port b (data cache) compete for the RAM; a grant is held for a whole
// burst (command + BURST_COUNT beats). Ties go round robin by default.
// Optional build macro BURST_ARB_FIXED_PRIORITY_EN: port a always wins a tie.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    burst_ram_arbiter_if.slave        a,
    burst_ram_arbiter_if.slave        b,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]               br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [63:0]               br_rd_data,
    input  logic                      br_rd_data_ready,
    input  logic                      br_busy
);
    localparam int CNT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    // Write: command cycle carries beat 0, WRITE state carries the rest.
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(BURST_COUNT - 2);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                    state, state_next;
    logic                      owner, owner_next;
    logic                      last_winner, last_winner_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [63:0]               a_hold, b_hold;
    logic                      grant, winner, sel;
    logic                      fwd_a, fwd_b;
    logic                      src_cmd;
    logic [DEPTH_BITWIDTH-1:0] src_addr;
    logic [63:0]               src_wr_data;
    logic [7:0]                src_data_mask;

    // Tie-break between simultaneous requests; a lone request always wins.
    always_comb begin
        winner = b.cmd_en;
        if (a.cmd_en && b.cmd_en) begin
`ifdef BURST_ARB_FIXED_PRIORITY_EN
            winner = 1'b0;
`else
            winner = ~last_winner;
`endif
        end
    end

    // A grant is only possible from IDLE with the RAM ready and out of reset.
    assign grant = !rst && (state == IDLE) && !br_busy && (a.cmd_en || b.cmd_en);

    // Source port: the winner on the command cycle, the owner afterwards.
    assign sel           = (state == IDLE) ? winner : owner;
    assign src_cmd       = sel ? b.cmd       : a.cmd;
    assign src_addr      = sel ? b.addr      : a.addr;
    assign src_wr_data   = sel ? b.wr_data   : a.wr_data;
    assign src_data_mask = sel ? b.data_mask : a.data_mask;

    // Next-state logic plus the BurstRAM-side and ack outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_next       = state;
        owner_next       = owner;
        last_winner_next = last_winner;
        cnt_next         = cnt;
        br_cmd           = 1'b0;
        br_cmd_en        = 1'b0;
        br_addr          = '0;
        br_wr_data       = '0;
        br_data_mask     = '0;
        a.cmd_ack        = 1'b0;
        b.cmd_ack        = 1'b0;
        fwd_a            = 1'b0;
        fwd_b            = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    br_cmd           = src_cmd;
                    br_cmd_en        = 1'b1;
                    br_addr          = src_addr;
                    br_wr_data       = src_wr_data;
                    br_data_mask     = src_data_mask;
                    a.cmd_ack        = ~winner;
                    b.cmd_ack        = winner;
                    owner_next       = winner;
                    last_winner_next = winner;
                    cnt_next         = '0;
                    state_next       = src_cmd ? WRITE : READ;
                end
            end
            WRITE: begin
                br_cmd       = src_cmd;
                br_addr      = src_addr;
                br_wr_data   = src_wr_data;
                br_data_mask = src_data_mask;
                if (cnt == WR_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READ: begin
                if (br_rd_data_ready) begin
                    fwd_a = ~owner;
                    fwd_b = owner;
                    if (cnt == RD_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register updates together at the edge.
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_winner <= 1'b1;
            cnt         <= '0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            last_winner <= last_winner_next;
            cnt         <= cnt_next;
        end
    end

    // Each port remembers the last beat it was given while it is not reading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (fwd_a) a_hold <= br_rd_data;
            if (fwd_b) b_hold <= br_rd_data;
        end
    end

    // Read path: the owner sees the RAM bus live, the other port its held beat.
    assign a.rd_data       = (state == READ && !owner) ? br_rd_data : a_hold;
    assign b.rd_data       = (state == READ &&  owner) ? br_rd_data : b_hold;
    assign a.rd_data_ready = fwd_a;
    assign b.rd_data_ready = fwd_b;

    // Busy depends only on registered state, the RAM's busy and reset.
    assign a.busy = rst | (state != IDLE) | br_busy;
    assign b.busy = rst | (state != IDLE) | br_busy;
endmodule
